// File: rtl/global_history_pht_if.sv
// ----------------------------------------------------------------------------
// global_history_pht_if
//
// Purpose:
//   Groups the lookup, speculative-history, training and status signals of
//   the gshare direction predictor into one bundle. The fetch/decode/resolve
//   side of the pipeline uses the master modport. The predictor uses the
//   slave modport.
//
// Signals:
//   pcF          fetch-stage PC used for the combinational lookup
//   pred_takenF  predicted direction for pcF
//   pred_idxF    PHT index used for this lookup (travels down the pipe)
//   pred_ghrF    speculative GHR used for this lookup (travels down the pipe)
//   spec_en      branch in decode advancing this cycle
//   spec_taken   that branch's predicted direction
//   res_en       branch resolved this cycle
//   res_idx      PHT index carried with the resolved branch
//   res_ghr      GHR carried with the resolved branch (pre-shift)
//   res_taken    actual direction of the resolved branch
//   res_mispred  actual != predicted, qualified by res_en
//   ready        high once the PHT initialisation sweep has finished
//   mispred_cnt  saturating count of qualified mispredicts
// ----------------------------------------------------------------------------
interface global_history_pht_if #(
    parameter int IDX_BITS = 8,
    parameter int GHR_BITS = 8,
    parameter int CNT_BITS = 16
);
    logic [31:0]         pcF;
    logic                pred_takenF;
    logic [IDX_BITS-1:0] pred_idxF;
    logic [GHR_BITS-1:0] pred_ghrF;
    logic                spec_en;
    logic                spec_taken;
    logic                res_en;
    logic [IDX_BITS-1:0] res_idx;
    logic [GHR_BITS-1:0] res_ghr;
    logic                res_taken;
    logic                res_mispred;
    logic                ready;
    logic [CNT_BITS-1:0] mispred_cnt;

    modport master (
        output pcF,
        output spec_en,
        output spec_taken,
        output res_en,
        output res_idx,
        output res_ghr,
        output res_taken,
        output res_mispred,
        input  pred_takenF,
        input  pred_idxF,
        input  pred_ghrF,
        input  ready,
        input  mispred_cnt
    );

    modport slave (
        input  pcF,
        input  spec_en,
        input  spec_taken,
        input  res_en,
        input  res_idx,
        input  res_ghr,
        input  res_taken,
        input  res_mispred,
        output pred_takenF,
        output pred_idxF,
        output pred_ghrF,
        output ready,
        output mispred_cnt
    );
endinterface

// File: rtl/global_history_pht.sv
// ----------------------------------------------------------------------------
// global_history_pht
//
// Purpose:
//   Gshare direction predictor for the fetch-stage PC select. The fetch PC is
//   XORed with a speculative global history register (GHR) to index a table
//   of 2-bit saturating counters (PHT). The lookup is combinational. The GHR
//   shifts speculatively as branches leave decode. It is rebuilt from the
//   history carried with a resolved branch when that branch mispredicted.
//   After reset the PHT is swept to "weakly not-taken", one entry per cycle,
//   before predictions are enabled.
//
// Ports:
//   clk   clock; all state updates on the rising edge
//   rst   synchronous reset, active-low (rst == 0 resets)
//   bus   global_history_pht_if.slave
//           lookup : pcF -> pred_takenF, pred_idxF, pred_ghrF
//           decode : spec_en, spec_taken
//           resolve: res_en, res_idx, res_ghr, res_taken, res_mispred
//           status : ready, mispred_cnt
//
// GHR_BITS must be at least 2 and no larger than IDX_BITS.
// ----------------------------------------------------------------------------
module global_history_pht #(
    parameter int IDX_BITS = 8,
    parameter int GHR_BITS = 8,
    parameter int CNT_BITS = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    global_history_pht_if.slave  bus
);
    localparam int ENTRIES = 1 << IDX_BITS;

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic [IDX_BITS-1:0] ptr_q;
    logic [IDX_BITS-1:0] ptr_d;
    logic [GHR_BITS-1:0] ghr_q;
    logic [GHR_BITS-1:0] ghr_d;
    logic [CNT_BITS-1:0] cnt_q;
    logic [CNT_BITS-1:0] cnt_d;

    logic [1:0]          pht [ENTRIES];

    logic                run;
    logic [IDX_BITS-1:0] lookup_idx;
    logic [1:0]          train_old;
    logic [1:0]          train_new;
    logic                mispredict;

    // Only PC bits [IDX_BITS+1:2] take part in indexing.
    logic                unused_pc_bits;
    assign unused_pc_bits = ^{bus.pcF[31:IDX_BITS+2], bus.pcF[1:0]};

    assign run = (state_q == ST_RUN);

    // The GHR is zero-extended up to the index width before the XOR.
    assign lookup_idx = bus.pcF[IDX_BITS+1:2] ^ IDX_BITS'(ghr_q);

    // The PHT holds uninitialised entries until the sweep completes.
    // Gating with run keeps the prediction at not-taken until then.
    assign bus.pred_takenF = run & pht[lookup_idx][1];
    assign bus.pred_idxF   = lookup_idx;
    assign bus.pred_ghrF   = ghr_q;
    assign bus.ready       = run;
    assign bus.mispred_cnt = cnt_q;

    assign mispredict = bus.res_en & bus.res_mispred;

    // Saturating counter update for the resolved branch's entry.
    always_comb begin
        train_old = pht[bus.res_idx];
        train_new = train_old;
        if (bus.res_taken) begin
            if (train_old != 2'b11) begin
                train_new = train_old + 2'd1;
            end
        end else begin
            if (train_old != 2'b00) begin
                train_new = train_old - 2'd1;
            end
        end
    end

    // Next-state logic. A mispredict flushes the younger branch in decode,
    // so the repaired history wins over a same-cycle speculative shift.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        ghr_d   = ghr_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_INIT: begin
                ptr_d = ptr_q + IDX_BITS'(1);
                if (ptr_q == IDX_BITS'(ENTRIES - 1)) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (mispredict) begin
                    ghr_d = {bus.res_ghr[GHR_BITS-2:0], bus.res_taken};
                    if (cnt_q != {CNT_BITS{1'b1}}) begin
                        cnt_d = cnt_q + CNT_BITS'(1);
                    end
                end else if (bus.spec_en) begin
                    ghr_d = {ghr_q[GHR_BITS-2:0], bus.spec_taken};
                end
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_INIT;
            ptr_q   <= '0;
            ghr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            ghr_q   <= ghr_d;
            cnt_q   <= cnt_d;
        end
    end

    // The table is not reset directly. The sweep rewrites every entry after
    // each reset. A lookup in a training cycle sees the old counter, because
    // the new value lands at the clock edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            if (state_q == ST_INIT) begin
                pht[ptr_q] <= 2'b01;
            end else if (bus.res_en) begin
                pht[bus.res_idx] <= train_new;
            end
        end
    end

endmodule
